// File: rtl/wb_regfile.sv
// wb_regfile: writeback result select, 32x32 register file,
// two bypassed read ports, debug read port and commit counter.
module wb_regfile #(
  parameter int BYPASS  = 1,
  parameter int COUNT_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               regWriteW,
  input  logic               MemToRegW,
  input  logic [31:0]        ALUOutW,
  input  logic [31:0]        ReadDataW,
  input  logic [4:0]         WriteRegW,
  input  logic [4:0]         RA1,
  input  logic [4:0]         RA2,
  output logic [31:0]        RD1,
  output logic [31:0]        RD2,
  output logic [31:0]        ResultW,
  input  logic [4:0]         DbgAddr,
  output logic [31:0]        DbgData,
  output logic [COUNT_W-1:0] WbCount
);

  logic [31:0]        r_regs [32];
  logic [COUNT_W-1:0] r_cnt;

  logic w_commit;
  logic w_hit1;
  logic w_hit2;

  assign ResultW  = MemToRegW ? ReadDataW : ALUOutW;
  assign w_commit = regWriteW && (WriteRegW != 5'd0);

  assign w_hit1 = (BYPASS != 0) && w_commit
               && (RA1 == WriteRegW);
  assign w_hit2 = (BYPASS != 0) && w_commit
               && (RA2 == WriteRegW);

  // Entry 0 is held at zero, but reads of index 0
  // are still forced to zero so a bypass can never leak.
  assign RD1 = (RA1 == 5'd0) ? 32'h0
             : w_hit1        ? ResultW
             :                 r_regs[RA1];

  assign RD2 = (RA2 == 5'd0) ? 32'h0
             : w_hit2        ? ResultW
             :                 r_regs[RA2];

  assign DbgData = (DbgAddr == 5'd0) ? 32'h0
                 : r_regs[DbgAddr];

  assign WbCount = r_cnt;

  // Commit the writeback result; reset clears storage and count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'h0;
      end
      r_cnt <= '0;
    end else if (w_commit) begin
      r_regs[WriteRegW] <= ResultW;
      r_cnt             <= r_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile with
// default, no-bypass and 4-bit-counter instances.
module tb_wb_regfile;

  logic        CLK = 1'b0;
  logic        RST;
  logic        regWriteW;
  logic        MemToRegW;
  logic [31:0] ALUOutW;
  logic [31:0] ReadDataW;
  logic [4:0]  WriteRegW;
  logic [4:0]  RA1;
  logic [4:0]  RA2;
  logic [4:0]  DbgAddr;

  logic [31:0] RD1, RD2, ResultW, DbgData;
  logic [31:0] WbCount;
  logic [31:0] nRD1, nRD2, nResultW, nDbgData;
  logic [31:0] nWbCount;
  logic [31:0] cRD1, cRD2, cResultW, cDbgData;
  logic [3:0]  cWbCount;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] sb [$];
  logic [31:0] exp_v;

  logic [31:0] m_reg [32];
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;

  always #5 CLK = ~CLK;

  wb_regfile dut (
    .CLK(CLK), .RST(RST),
    .regWriteW(regWriteW), .MemToRegW(MemToRegW),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
    .WriteRegW(WriteRegW), .RA1(RA1), .RA2(RA2),
    .RD1(RD1), .RD2(RD2), .ResultW(ResultW),
    .DbgAddr(DbgAddr), .DbgData(DbgData),
    .WbCount(WbCount)
  );

  wb_regfile #(.BYPASS(0)) dut_nb (
    .CLK(CLK), .RST(RST),
    .regWriteW(regWriteW), .MemToRegW(MemToRegW),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
    .WriteRegW(WriteRegW), .RA1(RA1), .RA2(RA2),
    .RD1(nRD1), .RD2(nRD2), .ResultW(nResultW),
    .DbgAddr(DbgAddr), .DbgData(nDbgData),
    .WbCount(nWbCount)
  );

  wb_regfile #(.COUNT_W(4)) dut_c4 (
    .CLK(CLK), .RST(RST),
    .regWriteW(regWriteW), .MemToRegW(MemToRegW),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
    .WriteRegW(WriteRegW), .RA1(RA1), .RA2(RA2),
    .RD1(cRD1), .RD2(cRD2), .ResultW(cResultW),
    .DbgAddr(DbgAddr), .DbgData(cDbgData),
    .WbCount(cWbCount)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_cnt  = 32'h0;
    m_cnt4 = 4'h0;
  endtask

  task automatic set_rst(input logic v);
    RST = v;
    if (v) model_reset();
  endtask

  task automatic drive(input logic we, input logic m2r,
                       input logic [31:0] alu,
                       input logic [31:0] rdat,
                       input logic [4:0] wr);
    regWriteW = we;
    MemToRegW = m2r;
    ALUOutW   = alu;
    ReadDataW = rdat;
    WriteRegW = wr;
  endtask

  // Advance one rising edge; the model commits what the
  // inputs present at the edge, then sampling is 1ns later.
  task automatic tick();
    logic        c;
    logic [31:0] v;
    c = regWriteW && (WriteRegW != 5'd0) && !RST;
    v = MemToRegW ? ReadDataW : ALUOutW;
    @(posedge CLK);
    if (c) begin
      m_reg[WriteRegW] = v;
      m_cnt  = m_cnt + 32'd1;
      m_cnt4 = m_cnt4 + 4'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    RA1 = 5'd0; RA2 = 5'd0; DbgAddr = 5'd7;
    set_rst(1'b1);
    #1;
    sb.push_back(32'h0);
    exp_v = sb.pop_front(); n_checks++;
    if (WbCount !== exp_v) begin
      n_err++;
      $display("FAIL reset_count got=%h exp=%h", WbCount, exp_v);
    end
    tick();
    set_rst(1'b0);
    drive(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 5'd5);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    DbgAddr = 5'd5; RA1 = 5'd5;
    #1;
    sb.push_back(m_reg[5]);
    exp_v = sb.pop_front(); n_checks++;
    if (DbgData !== exp_v) begin
      n_err++;
      $display("FAIL preload_r5 got=%h exp=%h", DbgData, exp_v);
    end
    #2;
    set_rst(1'b1);
    sb.push_back(m_reg[5]);
    sb.push_back(m_cnt);
    sb.push_back(32'h0);
    #1;
    exp_v = sb.pop_front(); n_checks++;
    if (DbgData !== exp_v) begin
      n_err++;
      $display("FAIL async_rst_r5 got=%h exp=%h", DbgData, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (WbCount !== exp_v) begin
      n_err++;
      $display("FAIL async_rst_cnt got=%h exp=%h", WbCount, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (RD1 !== exp_v) begin
      n_err++;
      $display("FAIL async_rst_rd1 got=%h exp=%h", RD1, exp_v);
    end
    tick();
    set_rst(1'b0);
  endtask

  task automatic test_mux();
    drive(1'b1, 1'b0, 32'h12345678, 32'hAAAA5555, 5'd8);
    DbgAddr = 5'd8;
    #1;
    sb.push_back(32'h12345678);
    exp_v = sb.pop_front(); n_checks++;
    if (ResultW !== exp_v) begin
      n_err++;
      $display("FAIL resultw_alu got=%h exp=%h", ResultW, exp_v);
    end
    sb.push_back(32'h12345678);
    sb.push_back(32'd1);
    tick();
    exp_v = sb.pop_front(); n_checks++;
    if (DbgData !== exp_v) begin
      n_err++;
      $display("FAIL commit_r8 got=%h exp=%h", DbgData, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (WbCount !== exp_v) begin
      n_err++;
      $display("FAIL count_1 got=%h exp=%h", WbCount, exp_v);
    end
    drive(1'b1, 1'b1, 32'h12345678, 32'hAAAA5555, 5'd9);
    DbgAddr = 5'd9;
    sb.push_back(32'hAAAA5555);
    sb.push_back(32'd2);
    tick();
    exp_v = sb.pop_front(); n_checks++;
    if (DbgData !== exp_v) begin
      n_err++;
      $display("FAIL commit_r9 got=%h exp=%h", DbgData, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (WbCount !== exp_v) begin
      n_err++;
      $display("FAIL count_2 got=%h exp=%h", WbCount, exp_v);
    end
  endtask

  task automatic test_r0();
    drive(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd0);
    RA1 = 5'd0; RA2 = 5'd0; DbgAddr = 5'd0;
    #1;
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    exp_v = sb.pop_front(); n_checks++;
    if (RD1 !== exp_v) begin
      n_err++;
      $display("FAIL r0_rd1 got=%h exp=%h", RD1, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (RD2 !== exp_v) begin
      n_err++;
      $display("FAIL r0_rd2 got=%h exp=%h", RD2, exp_v);
    end
    sb.push_back(32'h0);
    sb.push_back(m_cnt);
    tick();
    exp_v = sb.pop_front(); n_checks++;
    if (DbgData !== exp_v) begin
      n_err++;
      $display("FAIL r0_dbg got=%h exp=%h", DbgData, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (WbCount !== exp_v) begin
      n_err++;
      $display("FAIL r0_count got=%h exp=%h", WbCount, exp_v);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b0, 32'h1, 32'h0, 5'd3);
    tick();
    drive(1'b1, 1'b0, 32'h77, 32'h0, 5'd3);
    RA1 = 5'd3; RA2 = 5'd3; DbgAddr = 5'd3;
    #1;
    sb.push_back(32'h77);
    sb.push_back(32'h77);
    sb.push_back(m_reg[3]);
    sb.push_back(m_reg[3]);
    sb.push_back(m_reg[3]);
    exp_v = sb.pop_front(); n_checks++;
    if (RD1 !== exp_v) begin
      n_err++;
      $display("FAIL byp_rd1 got=%h exp=%h", RD1, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (RD2 !== exp_v) begin
      n_err++;
      $display("FAIL byp_rd2 got=%h exp=%h", RD2, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (DbgData !== exp_v) begin
      n_err++;
      $display("FAIL byp_dbg got=%h exp=%h", DbgData, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (nRD1 !== exp_v) begin
      n_err++;
      $display("FAIL nobyp_rd1 got=%h exp=%h", nRD1, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (nRD2 !== exp_v) begin
      n_err++;
      $display("FAIL nobyp_rd2 got=%h exp=%h", nRD2, exp_v);
    end
    sb.push_back(32'h77);
    tick();
    exp_v = sb.pop_front(); n_checks++;
    if (DbgData !== exp_v) begin
      n_err++;
      $display("FAIL byp_after got=%h exp=%h", DbgData, exp_v);
    end
  endtask

  task automatic test_disabled();
    drive(1'b0, 1'b1, 32'hBAD, 32'hBAD0BAD0, 5'd4);
    RA1 = 5'd4; DbgAddr = 5'd4;
    #1;
    sb.push_back(m_reg[4]);
    exp_v = sb.pop_front(); n_checks++;
    if (RD1 !== exp_v) begin
      n_err++;
      $display("FAIL dis_rd1 got=%h exp=%h", RD1, exp_v);
    end
    sb.push_back(m_reg[4]);
    sb.push_back(m_cnt);
    tick();
    exp_v = sb.pop_front(); n_checks++;
    if (DbgData !== exp_v) begin
      n_err++;
      $display("FAIL dis_r4 got=%h exp=%h", DbgData, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (WbCount !== exp_v) begin
      n_err++;
      $display("FAIL dis_count got=%h exp=%h", WbCount, exp_v);
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #2;
    set_rst(1'b1);
    #2;
    set_rst(1'b0);
    DbgAddr = 5'd1;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b0, 32'h100 + i, 32'h0, 5'd1);
      tick();
      if (i == 15) begin
        sb.push_back(32'd15);
        exp_v = sb.pop_front(); n_checks++;
        if (32'(cWbCount) !== exp_v) begin
          n_err++;
          $display("FAIL wrap_15 got=%h exp=%h", cWbCount, exp_v);
        end
      end
    end
    sb.push_back(32'(m_cnt4));
    sb.push_back(32'd16);
    sb.push_back(32'h110);
    exp_v = sb.pop_front(); n_checks++;
    if (32'(cWbCount) !== exp_v) begin
      n_err++;
      $display("FAIL wrap_0 got=%h exp=%h", cWbCount, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (WbCount !== exp_v) begin
      n_err++;
      $display("FAIL wide_16 got=%h exp=%h", WbCount, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (cDbgData !== exp_v) begin
      n_err++;
      $display("FAIL wrap_r1 got=%h exp=%h", cDbgData, exp_v);
    end
    drive(1'b1, 1'b0, 32'h5A5A, 32'h0, 5'd1);
    tick();
    #2;
    set_rst(1'b1);
    tick();
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    exp_v = sb.pop_front(); n_checks++;
    if (cDbgData !== exp_v) begin
      n_err++;
      $display("FAIL rstc_r1 got=%h exp=%h", cDbgData, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (32'(cWbCount) !== exp_v) begin
      n_err++;
      $display("FAIL rstc_cnt got=%h exp=%h", cWbCount, exp_v);
    end
    #2;
    set_rst(1'b0);
    drive(1'b1, 1'b1, 32'h0, 32'hC0FFEE, 5'd1);
    tick();
    sb.push_back(32'hC0FFEE);
    sb.push_back(32'd1);
    exp_v = sb.pop_front(); n_checks++;
    if (DbgData !== exp_v) begin
      n_err++;
      $display("FAIL post_rst_r1 got=%h exp=%h", DbgData, exp_v);
    end
    exp_v = sb.pop_front(); n_checks++;
    if (WbCount !== exp_v) begin
      n_err++;
      $display("FAIL post_rst_cnt got=%h exp=%h", WbCount, exp_v);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    model_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    test_reset();
    test_mux();
    test_r0();
    test_bypass();
    test_disabled();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
